life_sequencer: RTL and testbench

Generation controller for the 8x8 Life grid. Holds the current 64-bit grid register, loads a seed on command, and sequences the combinational evolve datapath: single generations on demand, or free-running at a programmable tick rate. Sits between the seed/init source and the datapath, replacing the ad-hoc init mux with a clocked, counted, pausable sequencer. Downstream display logic reads its grid and status outputs.

---
 rtl/life_pkg.sv | 10 +
 rtl/life_tick_div.sv | 29 ++
 rtl/life_sequencer.sv | 92 +++++++++
 tb/tb_life_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and constants for the Life generation sequencer.
package life_pkg;

  localparam int unsigned DEFAULT_GRID_W = 64;

  typedef enum logic [1:0] {IDLE, RUN, STABLE} life_state_t;

  typedef logic [DEFAULT_GRID_W-1:0] grid_t;

endpackage

// File: rtl/life_tick_div.sv
// Free-run pacing counter: counts 0..TICK_DIV-1 while enabled, pulses term on the last count.
module life_tick_div #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic term
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign term = en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= term ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Generation controller for the 8x8 Life grid: seed load, single step, paced free-run.
// Optional still-life detection enabled by defining LIFE_STABLE_DETECT_EN.
module life_sequencer
  import life_pkg::*;
#(
  parameter int unsigned GRID_W   = DEFAULT_GRID_W,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned GEN_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] seed,
  input  logic              load,
  input  logic              run,
  input  logic              step,
  input  logic [GRID_W-1:0] grid_next,
  output logic [GRID_W-1:0] grid,
  output logic [GEN_W-1:0]  gen_count,
  output logic              gen_strobe,
  output logic              running,
  output logic              stable,
  output logic              extinct
);

  localparam logic [GEN_W-1:0] GEN_MAX = '1;

  life_state_t state_q;
  logic        tick_en;
  logic        tick_term;
  logic        advance;
  logic        same;

  // Counter only advances in RUN with run held; any other cycle parks it at 0.
  assign tick_en = (state_q == RUN) && run && !load;

  life_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .en   (tick_en),
    .clr  (!tick_en),
    .term (tick_term)
  );

`ifdef LIFE_STABLE_DETECT_EN
  assign same = (grid_next == grid);
`else
  assign same = 1'b0;
`endif

  assign advance = !load && (((state_q == IDLE) && step) || tick_term);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grid       <= '0;
      gen_count  <= '0;
      gen_strobe <= 1'b0;
      state_q    <= IDLE;
    end else begin
      gen_strobe <= 1'b0;
      if (load) begin
        grid      <= seed;
        gen_count <= '0;
        state_q   <= IDLE;
      end else begin
        if (advance) begin
          grid       <= grid_next;
          gen_strobe <= 1'b1;
          if (gen_count != GEN_MAX) gen_count <= gen_count + 1'b1;
        end
        case (state_q)
          IDLE: begin
            if (advance && same)  state_q <= STABLE;
            else if (!step && run) state_q <= RUN;
          end
          RUN: begin
            if (!run)                 state_q <= IDLE;
            else if (advance && same) state_q <= STABLE;
          end
          STABLE:  state_q <= STABLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign running = (state_q == RUN);
  assign stable  = (state_q == STABLE);
  assign extinct = (grid == '0);

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer with a bounded-edge Life model as the external datapath.
module tb_life_sequencer;

  localparam logic [63:0] BLINKER = 64'h0000_0000_0007_0000;
  localparam logic [63:0] VERT    = 64'h0000_0000_0202_0200;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0018_1800;
  localparam logic [63:0] OTHER   = 64'h0000_0000_0004_0207;

`ifdef LIFE_STABLE_DETECT_EN
  localparam bit DETECT = 1'b1;
`else
  localparam bit DETECT = 1'b0;
`endif

  typedef struct {
    logic [63:0] grid;
    logic [15:0] gen;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] seed;
  logic        load, run, step;
  logic [63:0] grid_next, grid;
  logic [15:0] gen_count;
  logic        gen_strobe, running, stable, extinct;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [63:0] model;
  logic [15:0] model_gen;

  always #5 clk = ~clk;

  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] nxt;
    nxt = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                (c + dc) >= 0 && (c + dc) < 8 && g[(r + dr) * 8 + c + dc])
              n++;
          end
        end
        nxt[r * 8 + c] = (n == 3) || (g[r * 8 + c] && n == 2);
      end
    end
    return nxt;
  endfunction

  assign grid_next = life(grid);

  life_sequencer #(
    .GRID_W  (64),
    .TICK_DIV(4),
    .GEN_W   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seed      (seed),
    .load      (load),
    .run       (run),
    .step      (step),
    .grid_next (grid_next),
    .grid      (grid),
    .gen_count (gen_count),
    .gen_strobe(gen_strobe),
    .running   (running),
    .stable    (stable),
    .extinct   (extinct)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the result of one advance from the model state.
  task automatic push_adv();
    exp_t e;
    model = life(model);
    if (model_gen != 16'hFFFF) model_gen = model_gen + 16'd1;
    e.grid = model;
    e.gen  = model_gen;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (gen_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("strobe_unexpected", 64'(gen_strobe), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_grid", grid, e.grid);
        chk("sb_gen", 64'(gen_count), 64'(e.gen));
      end
    end
  end

  initial begin
    reset = 1'b1; seed = '0; load = 0; run = 0; step = 0;
    #3;
    chk("rst_grid", grid, 64'd0);
    chk("rst_gen", 64'(gen_count), 64'd0);
    chk("rst_strobe", 64'(gen_strobe), 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_stable", 64'(stable), 64'd0);
    chk("rst_extinct", 64'(extinct), 64'd1);
    @(negedge clk); reset = 1'b0;

    // Load blinker
    seed = BLINKER; load = 1;
    @(negedge clk); load = 0;
    model = BLINKER; model_gen = 0;
    chk("load_grid", grid, BLINKER);
    chk("load_gen", 64'(gen_count), 64'd0);
    chk("load_extinct", 64'(extinct), 64'd0);
    chk("load_stable", 64'(stable), 64'd0);

    // Two single steps
    step = 1; push_adv();
    @(negedge clk); step = 0;
    chk("step1_vertical", grid, VERT);
    chk("step1_strobe", 64'(gen_strobe), 64'd1);
    @(negedge clk);
    chk("step1_strobe_off", 64'(gen_strobe), 64'd0);
    step = 1; push_adv();
    @(negedge clk); step = 0;
    @(negedge clk);
    chk("step2_grid", grid, BLINKER);
    chk("step2_gen", 64'(gen_count), 64'd2);

    // Free-run, advances on the 4th, 8th and 12th edge after entering RUN
    run = 1;
    push_adv(); push_adv(); push_adv();
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 0)  chk("run_running", 64'(running), 64'd1);
      if (k == 3)  chk("run_gen_k3", 64'(gen_count), 64'd2);
      if (k == 4)  chk("run_gen_k4", 64'(gen_count), 64'd3);
      if (k == 7)  chk("run_gen_k7", 64'(gen_count), 64'd3);
      if (k == 8)  chk("run_gen_k8", 64'(gen_count), 64'd4);
      if (k == 12) chk("run_gen_k12", 64'(gen_count), 64'd5);
    end
    run = 0;
    @(negedge clk);
    chk("pause_running", 64'(running), 64'd0);
    repeat (5) @(negedge clk);
    chk("pause_gen", 64'(gen_count), 64'd5);
    chk("pause_grid", grid, model);

    // load + step while in RUN: load wins, no advance
    run = 1;
    @(negedge clk); @(negedge clk);
    chk("ls_running_before", 64'(running), 64'd1);
    seed = OTHER; load = 1; step = 1;
    @(negedge clk); load = 0; step = 0; run = 0;
    model = OTHER; model_gen = 0;
    chk("ls_grid", grid, OTHER);
    chk("ls_gen", 64'(gen_count), 64'd0);
    chk("ls_running", 64'(running), 64'd0);
    @(negedge clk);
    chk("ls_gen_hold", 64'(gen_count), 64'd0);

    // Block still life under run, with a step pulse that must be ignored
    seed = BLOCK; load = 1; run = 1;
    @(negedge clk); load = 0;
    model = BLOCK; model_gen = 0;
    push_adv();
    if (!DETECT) begin push_adv(); push_adv(); end
    for (int k = 0; k <= 12; k++) begin
      step = (k == 6);
      @(negedge clk);
      if (k == 4) begin
        chk("blk_gen_k4", 64'(gen_count), 64'd1);
        chk("blk_stable_k4", 64'(stable), 64'(DETECT));
        chk("blk_running_k4", 64'(running), 64'(!DETECT));
      end
    end
    step = 0;
    chk("blk_gen_k12", 64'(gen_count), DETECT ? 64'd1 : 64'd3);
    run = 0;
    @(negedge clk);
    step = 1;
    if (!DETECT) push_adv();
    @(negedge clk); step = 0;
    @(negedge clk);
    chk("blk_gen_final", 64'(gen_count), DETECT ? 64'd1 : 64'd4);
    chk("blk_stable_final", 64'(stable), 64'(DETECT));
    chk("blk_grid_final", grid, BLOCK);

    // Asynchronous reset mid-run at tick 2
    seed = BLINKER; load = 1; run = 1;
    @(negedge clk); load = 0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mid_running", 64'(running), 64'd1);
    #1 reset = 1;
    #1;
    chk("arst_grid", grid, 64'd0);
    chk("arst_gen", 64'(gen_count), 64'd0);
    chk("arst_extinct", 64'(extinct), 64'd1);
    chk("arst_running", 64'(running), 64'd0);
    run = 0;
    @(negedge clk); reset = 0;
    @(negedge clk);
    chk("post_rst_grid", grid, 64'd0);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
